// File: rtl/mem_arbiter.sv
// Two-master arbiter for the shared 8-bit RAM: DMA has priority up to a burst limit,
// then a pending CPU request is granted. Every access is a fixed 4-cycle sequence.
//
// state   | meaning
// IDLE    | no access in flight; arbitrate on each rising edge
// ISSUE   | drive latched address/data and exactly one RAM strobe
// CAPTURE | RAM read data valid; owner's rdata loads at end of cycle (reads only)
// ACK     | one-cycle acknowledge to the owner, then back to IDLE
module mem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  state_t            state, state_nxt;
  logic [3:0]        burst_cnt, burst_nxt;
  logic              grant_cpu, grant_dma;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_we;

  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    grant_dma = 1'b0;
    grant_cpu = 1'b0;
    case (state)
      IDLE: begin
        grant_dma = dma_req && (!cpu_req || (burst_cnt < BURST_MAX));
        grant_cpu = cpu_req && !grant_dma;
        if (grant_dma || grant_cpu) state_nxt = ISSUE;
        // a DMA grant with cpu_req high only happens below the limit, so this saturates
        if (grant_cpu || !cpu_req) burst_nxt = 4'd0;
        else if (grant_dma)        burst_nxt = burst_cnt + 4'd1;
      end
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      burst_cnt <= 4'd0;
      owner     <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      if (grant_dma) begin
        owner     <= 1'b1;
        lat_addr  <= dma_addr;
        lat_wdata <= dma_wdata;
        lat_we    <= dma_we;
      end else if (grant_cpu) begin
        owner     <= 1'b0;
        lat_addr  <= cpu_addr;
        lat_wdata <= cpu_wdata;
        lat_we    <= cpu_we;
      end
      if (state == CAPTURE && !lat_we) begin
        if (owner) dma_rdata <= mem_rdata;
        else       cpu_rdata <= mem_rdata;
      end
    end
  end

  // strobes and acks decode straight from state so an async reset drops them at once
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign mem_we    = (state == ISSUE) &&  lat_we;
  assign mem_re    = (state == ISSUE) && !lat_we;
  assign cpu_ack   = (state == ACK) && !owner;
  assign dma_ack   = (state == ACK) &&  owner;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural RAM; expected RAM operations and
// acknowledges are queued by the stimulus and checked by an independent monitor.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  logic [7:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0;
  logic [7:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic       cpu_ack, dma_ack, mem_we, mem_re, busy, owner;

  mem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // behavioural RAM: read data valid the cycle after mem_re
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic we; logic [7:0] addr; logic [7:0] wdata; } op_t;
  typedef struct { logic who; logic we; logic [7:0] rdata; } ack_t;
  op_t  opq [$];
  ack_t ackq [$];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // monitor: pops expectations whenever the DUT strobes the RAM or acknowledges
  logic [7:0] m_cpu_rd = 0, m_dma_rd = 0;
  int         strobe_cyc = -100;
  initial begin
    op_t  o;
    ack_t a;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_cpu_rd = 0;
        m_dma_rd = 0;
      end else begin
        if (mem_we || mem_re) begin
          chk("one_strobe", {mem_we, mem_re} == 2'b01 || {mem_we, mem_re} == 2'b10, 1);
          chk("strobe_spacing", (cyc - strobe_cyc) >= 4, 1);
          strobe_cyc = cyc;
          if (opq.size() == 0) chk("unexpected_strobe", 1, 0);
          else begin
            o = opq.pop_front();
            chk("mem_we", mem_we, o.we);
            chk("mem_addr", mem_addr, o.addr);
            if (o.we) chk("mem_wdata", mem_wdata, o.wdata);
          end
        end
        if (cpu_ack || dma_ack) begin
          chk("ack_latency", cyc - strobe_cyc, 2);
          if (ackq.size() == 0) chk("unexpected_ack", 1, 0);
          else begin
            a = ackq.pop_front();
            chk("ack_who", {cpu_ack, dma_ack}, a.who ? 2'b01 : 2'b10);
            chk("owner", owner, a.who);
            if (!a.we) begin
              if (a.who) m_dma_rd = a.rdata;
              else       m_cpu_rd = a.rdata;
            end
            chk("cpu_rdata", cpu_rdata, m_cpu_rd);
            chk("dma_rdata", dma_rdata, m_dma_rd);
          end
        end
      end
    end
  end

  task automatic push(input logic who, input logic we, input logic [7:0] addr,
                      input logic [7:0] wdata, input logic [7:0] rdata);
    op_t  o;
    ack_t a;
    o.we = we; o.addr = addr; o.wdata = wdata;
    a.who = who; a.we = we; a.rdata = rdata;
    opq.push_back(o);
    ackq.push_back(a);
  endtask

  task automatic wait_acks(input int n, input int budget);
    int got = 0;
    for (int i = 0; i < budget && got < n; i++) begin
      @(negedge clk);
      if (cpu_ack || dma_ack) got++;
    end
    if (got < n) chk("ack_timeout", got, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[8'h2A] = 8'h5C;
    ram[8'h40] = 8'hAB;

    #2;
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_strobes", {mem_we, mem_re}, 0);
    chk("rst_acks", {cpu_ack, dma_ack}, 0);
    chk("rst_rdata", {cpu_rdata, dma_rdata}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    repeat (2) @(negedge clk);
    reset = 0;

    // CPU read of 0x2A
    @(negedge clk);
    push(0, 0, 8'h2A, 8'h00, 8'h5C);
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h2A;
    @(negedge clk);
    chk("t1_issue_re", {busy, mem_re}, 2'b11);
    wait_acks(1, 10);
    cpu_req = 0;

    // DMA write 0x77 to 0x10, then CPU read 0x10
    @(negedge clk);
    push(1, 1, 8'h10, 8'h77, 8'h00);
    dma_req = 1; dma_we = 1; dma_addr = 8'h10; dma_wdata = 8'h77;
    wait_acks(1, 10);
    dma_req = 0;
    push(0, 0, 8'h10, 8'h00, 8'h77);
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h10;
    wait_acks(1, 10);
    cpu_req = 0;

    // both held: D,D,D,D,C,D,D,D,D,C
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      if (k == 4 || k == 9) push(0, 0, 8'h2A, 8'h00, 8'h5C);
      else                  push(1, 0, 8'h10, 8'h00, 8'h77);
    end
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h2A;
    dma_req = 1; dma_we = 0; dma_addr = 8'h10;
    wait_acks(10, 60);
    cpu_req = 0; dma_req = 0;

    // cpu_req pulsed for the grant edge only
    @(negedge clk);
    push(0, 0, 8'h40, 8'h00, 8'hAB);
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h40;
    @(negedge clk);
    cpu_req = 0;
    wait_acks(1, 10);
    repeat (6) @(negedge clk);
    chk("t4_idle", busy, 0);

    // write keeps cpu_rdata at 0xAB
    push(0, 1, 8'h41, 8'h01, 8'h00);
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h41; cpu_wdata = 8'h01;
    wait_acks(1, 10);
    cpu_req = 0;
    @(negedge clk);
    chk("t5_ram_written", ram[8'h41], 8'h01);
    chk("t5_cpu_rdata", cpu_rdata, 8'hAB);

    // async reset in CAPTURE, DMA pending through reset
    opq.push_back('{we: 1'b0, addr: 8'h2A, wdata: 8'h00});
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h2A;
    @(negedge clk);
    cpu_req = 0;
    @(negedge clk);
    chk("t6_in_capture", busy, 1);
    #1 reset = 1;
    dma_req = 1; dma_we = 0; dma_addr = 8'h2A;
    #1;
    chk("t6_busy", busy, 0);
    chk("t6_strobes", {mem_we, mem_re}, 0);
    chk("t6_acks", {cpu_ack, dma_ack}, 0);
    chk("t6_rdata", {cpu_rdata, dma_rdata}, 0);
    repeat (3) @(negedge clk);
    push(1, 0, 8'h2A, 8'h00, 8'h5C);
    reset = 0;
    @(negedge clk);
    chk("t6_regrant", {busy, owner, mem_re}, 3'b111);
    wait_acks(1, 10);
    dma_req = 0;

    repeat (6) @(negedge clk);
    chk("final_idle", busy, 0);
    chk("opq_empty", opq.size(), 0);
    chk("ackq_empty", ackq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single 8-bit program/data RAM between two requesters: the CPU memory port and a DMA/program-loader port (serial loader, debug poke).
- Sits between both masters and the RAM. It latches the winning request, sequences a fixed 4-cycle access, returns read data and pulses a per-requester acknowledge.
- Arbitration is DMA-priority with a burst limit, so a continuous DMA stream cannot starve the CPU.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width.
- MAX_BURST, 4, maximum consecutive DMA grants while cpu_req is pending before the CPU must be granted. Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  CPU access request, level.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data, registered.
- cpu_ack  out  1  one-cycle completion pulse to CPU.
- dma_req  in  1  DMA access request, level.
- dma_we  in  1  1 = write, 0 = read.
- dma_addr  in  ADDR_W  DMA address.
- dma_wdata  in  DATA_W  DMA write data.
- dma_rdata  out  DATA_W  DMA read data, registered.
- dma_ack  out  1  one-cycle completion pulse to DMA.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_we  out  1  RAM write strobe.
- mem_re  out  1  RAM read strobe.
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_re.
- busy  out  1  high whenever state != IDLE.
- owner  out  1  0 = CPU, 1 = DMA; last granted requester.

Behaviour:
- Reset (async): state=IDLE, burst_cnt=0, owner=0. All outputs 0, including rdata registers, latched addr/wdata/we and both acks.
- FSM states: IDLE -> ISSUE -> CAPTURE -> ACK -> IDLE, one cycle each.
- IDLE arbitration, sampled at the rising edge:
  - only cpu_req: grant CPU.
  - only dma_req: grant DMA.
  - both, burst_cnt < MAX_BURST: grant DMA.
  - both, burst_cnt == MAX_BURST: grant CPU.
  - neither: stay in IDLE.
- Grant edge:
  - latch winner's addr, wdata and we into internal registers; set owner; go to ISSUE.
  - requester inputs only need to be stable at the grant edge.
- burst_cnt update:
  - increments, saturating at MAX_BURST, on each DMA grant made while cpu_req=1.
  - clears to 0 on any CPU grant.
  - clears to 0 in IDLE when cpu_req=0.
- ISSUE: mem_addr and mem_wdata driven from the latched registers. mem_we = latched we; mem_re = !latched we. Exactly one strobe is high, for exactly this cycle.
- CAPTURE: for reads, at the end of this cycle the owner's rdata register loads mem_rdata. For writes, rdata is unchanged. The other requester's rdata never changes.
- ACK:
  - owner's ack = 1 for exactly this cycle; the other ack stays 0.
  - rdata is already stable during ACK.
  - next state is always IDLE.
- Request protocol:
  - a requester deasserts req on the edge where it samples ack=1.
  - req still high in the following IDLE cycle is a new request.
- Latency and throughput: request sampled at edge 0 -> ack high in cycle 3 -> next grant possible at edge 4. Maximum rate is one access per 4 cycles.
- Requester drops req mid-access: the access still completes and ack is still pulsed. A mid-access req change has no effect.
- Both acks are never high together. mem_we and mem_re are never high together and are 0 outside ISSUE.
- mem_addr and mem_wdata hold the last latched values outside ISSUE.
- Reset mid-access: FSM returns to IDLE immediately, strobes drop asynchronously, no ack is generated, and the access is abandoned. A RAM write may or may not have occurred.

Test Plan:
- CPU read only: RAM[0x2A]=0x5C; cpu_req, we=0, addr=0x2A -> mem_re high in cycle 1 with mem_addr=0x2A; cpu_ack in cycle 3; cpu_rdata=0x5C; dma_ack stays 0.
- DMA write then CPU read: dma writes 0x77 to 0x10, then CPU reads 0x10 -> one mem_we pulse with addr=0x10, data=0x77; dma_ack cycle 3; cpu_rdata=0x77 at its ack; dma_rdata unchanged.
- Simultaneous requests, MAX_BURST=4, both req held continuously -> grant order D,D,D,D,C,D,D,D,D,C; owner toggles accordingly; no two accesses closer than 4 cycles.
- Requester drops req in ISSUE: cpu_req pulsed for the grant edge only -> access completes, cpu_ack pulses once, FSM returns to IDLE and stays there.
- Write preserves rdata: cpu_rdata=0xAB from a prior read; CPU write of 0x01 -> cpu_rdata remains 0xAB.
- Async reset in CAPTURE: assert reset mid-cycle -> busy, strobes and acks go to 0 without a clock; both rdata=0; after release a pending dma_req is granted at the next edge.
